// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST controller: FSM states,
// golden sum function and the Fibonacci LFSR tap table.
package adder_bist_pkg;

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    localparam int MAX_W    = 8;
    localparam int MAX_LFSR = 2*MAX_W + 1;

    // Bit k-1 set means term x^k is in the feedback polynomial; entry n is for an n-bit LFSR.
    localparam logic [MAX_LFSR-1:0] LFSR_TAPS [0:MAX_LFSR] = '{
        17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000,
        17'h00014,                         // 5:  x^5+x^3+1
        17'h00000,
        17'h00060,                         // 7:  x^7+x^6+1
        17'h00000,
        17'h00110,                         // 9:  x^9+x^5+1
        17'h00000,
        17'h00500,                         // 11: x^11+x^9+1
        17'h00000,
        17'h01C80,                         // 13: x^13+x^12+x^11+x^8+1
        17'h00000,
        17'h06000,                         // 15: x^15+x^14+1
        17'h00000,
        17'h12000                          // 17: x^17+x^14+1
    };

    function automatic logic [MAX_W:0] expected_sum(input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b,
                                                    input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_bist_ctrl_if.sv
// Operand/result bus between the BIST controller (master) and the adder under test (slave).
interface adder_bist_ctrl_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (output a, b, cin, input s, cout);
    modport slave  (input a, b, cin, output s, cout);
endinterface

// File: rtl/adder_bist_vecgen.sv
// Test vector source: exhaustive binary count, or maximal-length LFSR from seed 1
// when ADDER_BIST_LFSR_EN is defined. 'last' flags the final vector of the sweep.
module adder_bist_vecgen
    import adder_bist_pkg::*;
#(
    parameter int VW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [VW-1:0] vec,
    output logic          last
);

    logic [VW-1:0] vec_q, vec_d;

`ifdef ADDER_BIST_LFSR_EN
    localparam logic [VW-1:0] SEED = VW'(1);
    localparam logic [VW-1:0] TAPS = LFSR_TAPS[VW][VW-1:0];

    logic [VW-1:0] step;

    always_comb begin
        step  = {vec_q[VW-2:0], ^(vec_q & TAPS)};
        last  = (step == SEED);
        vec_d = vec_q;
        if (clear)        vec_d = SEED;
        else if (advance) vec_d = step;
    end

    always_ff @(posedge clk) begin
        if (rst) vec_q <= SEED;
        else     vec_q <= vec_d;
    end
`else
    always_comb begin
        last  = &vec_q;
        vec_d = vec_q;
        if (clear)        vec_d = '0;
        else if (advance) vec_d = vec_q + VW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) vec_q <= '0;
        else     vec_q <= vec_d;
    end
`endif

    assign vec = vec_q;

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST controller for a WIDTH-bit adder: sweeps vectors, checks {cout,s} against a+b+cin,
// logs error count and first failing vector. ADDER_BIST_LFSR_EN selects LFSR vector order.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    adder_bist_ctrl_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2*WIDTH+1:0]    err_count,
    output logic [WIDTH-1:0]      fail_a,
    output logic [WIDTH-1:0]      fail_b,
    output logic                  fail_cin
);

    localparam int VW = 2*WIDTH + 1;
    localparam int CW = 2*WIDTH + 2;
    localparam int EW = MAX_W + 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [CW-1:0]    err_q, err_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
    logic             fail_cin_q, fail_cin_d;

    logic             vg_clear, vg_advance, vg_last, mismatch;
    logic [VW-1:0]    vec;

    adder_bist_vecgen #(.VW(VW)) u_vecgen (
        .clk     (clk),
        .rst     (rst),
        .clear   (vg_clear),
        .advance (vg_advance),
        .vec     (vec),
        .last    (vg_last)
    );

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_cin_d = fail_cin_q;
        vg_clear   = 1'b0;
        vg_advance = 1'b0;
        mismatch   = (expected_sum(MAX_W'(a_q), MAX_W'(b_q), cin_q) != EW'({bus.cout, bus.s}));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = APPLY;
                    vg_clear   = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_d      = '0;
                    fail_a_d   = '0;
                    fail_b_d   = '0;
                    fail_cin_d = 1'b0;
                end
            end
            APPLY: begin
                a_d      = vec[2*WIDTH-1:WIDTH];
                b_d      = vec[WIDTH-1:0];
                cin_d    = vec[2*WIDTH];
                settle_d = SETTLE_INIT;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == '0) state_d  = CHECK;
                else                settle_d = settle_q - SW'(1);
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + CW'(1);
                    // err_count never returns to zero within a sweep, so zero marks the first failure
                    if (err_q == '0) begin
                        fail_a_d   = a_q;
                        fail_b_d   = b_q;
                        fail_cin_d = cin_q;
                    end
                end
                if (vg_last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    vg_advance = 1'b1;
                    state_d    = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_cin_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_cin_q <= fail_cin_d;
        end
    end

    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.cin   = cin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_cin  = fail_cin_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: behavioural adder with injectable faults, expected run
// results queued by the stimulus and checked by a monitor when done rises.
module tb_adder_bist_ctrl;

`ifdef ADDER_BIST_LFSR_EN
    localparam bit LFSR = 1'b1;
`else
    localparam bit LFSR = 1'b0;
`endif
    localparam int VECS   = LFSR ? 511 : 512;
    localparam int CYCLES = VECS * 3;

    typedef struct {
        int         err;
        bit         pass;
        bit         chk_fail;
        logic [3:0] fa;
        logic [3:0] fb;
        logic       fc;
        int         cycles;
        bit         zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       busy, done, pass, fail_cin;
    logic [9:0] err_count;
    logic [3:0] fail_a, fail_b;
    int         fault;
    logic [4:0] sum;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    adder_bist_ctrl_if #(.WIDTH(4)) bus ();

    adder_bist_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_a    (fail_a),
        .fail_b    (fail_b),
        .fail_cin  (fail_cin)
    );

    always #5 clk = ~clk;

    always_comb begin
        sum = {1'b0, bus.a} + {1'b0, bus.b} + {4'b0, bus.cin};
        if (fault == 1) sum[4] = 1'b0;
        if (fault == 2) sum[0] = 1'b1;
        bus.s    = sum[3:0];
        bus.cout = sum[4];
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: measures busy length, watches for the all-zero vector, checks results on done rise
    int  busy_cnt = 0;
    bit  zero_seen = 0, busy_prev = 0, done_prev = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt  = 0;
            zero_seen = 0;
        end else begin
            if (busy && !busy_prev) begin
                busy_cnt  = 0;
                zero_seen = 0;
            end
            if (busy) busy_cnt++;
            if (busy && busy_prev && {bus.cin, bus.a, bus.b} == 9'd0) zero_seen = 1;
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("err_count", err_count, e.err);
                    chk("pass", pass, e.pass);
                    chk("busy_at_done", busy, 0);
                    chk("busy_cycles", busy_cnt, e.cycles);
                    chk("zero_vector_applied", zero_seen, e.zero);
                    if (e.chk_fail) begin
                        chk("fail_a", fail_a, e.fa);
                        chk("fail_b", fail_b, e.fb);
                        chk("fail_cin", fail_cin, e.fc);
                    end
                end
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_fail_a"}, fail_a, 0);
        chk({tag, "_fail_b"}, fail_b, 0);
        chk({tag, "_fail_cin"}, fail_cin, 0);
        chk({tag, "_a"}, bus.a, 0);
        chk({tag, "_b"}, bus.b, 0);
        chk({tag, "_cin"}, bus.cin, 0);
    endtask

    function automatic exp_t mk(input int err, input bit p, input bit cf,
                                input logic [3:0] fa, input logic [3:0] fb, input logic fc);
        exp_t e;
        e.err = err; e.pass = p; e.chk_fail = cf;
        e.fa = fa; e.fb = fb; e.fc = fc;
        e.cycles = CYCLES;
        e.zero = !LFSR;
        return e;
    endfunction

    initial begin
        rst = 1'b1;
        start = 1'b0;
        fault = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Correct adder; final vector must remain on the bus
        sb.push_back(mk(0, 1, 1, 4'd0, 4'd0, 1'b0));
        pulse_start();
        wait_done();
        chk("hold_a", bus.a, LFSR ? 0 : 15);
        chk("hold_b", bus.b, LFSR ? 0 : 15);
        chk("hold_cin", bus.cin, 1);

        // cout stuck-at-0
        fault = 1;
        sb.push_back(mk(256, 0, !LFSR, 4'd1, 4'd15, 1'b0));
        pulse_start();
        wait_done();

        // s[0] stuck-at-1; the all-zero vector is a failure only in counter mode
        fault = 2;
        sb.push_back(mk(LFSR ? 255 : 256, 0, !LFSR, 4'd0, 4'd0, 1'b0));
        pulse_start();
        wait_done();

        // A second start mid-sweep must not restart or lengthen the run
        fault = 0;
        sb.push_back(mk(0, 1, 1, 4'd0, 4'd0, 1'b0));
        pulse_start();
        repeat (199) @(negedge clk);
        pulse_start();
        wait_done();

        // Reset mid-sweep aborts; no expectation is queued for the aborted run
        fault = 1;
        pulse_start();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("abort");
        rst = 1'b0;
        sb.push_back(mk(256, 0, !LFSR, 4'd1, 4'd15, 1'b0));
        pulse_start();
        wait_done();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
